// File: rtl/register_file_vectorial_pkg.sv
// rtl/register_file_vectorial_pkg.sv - default sizes and element/vector types for the vector register file
package register_file_vectorial_pkg;

  localparam int DEFAULT_WIDTH        = 32;
  localparam int DEFAULT_VECTOR_SIZE  = 16;
  localparam int DEFAULT_NUM_VECTORES = 8;

  typedef logic [DEFAULT_WIDTH-1:0] element_t;
  typedef element_t vector_t [DEFAULT_VECTOR_SIZE];

endpackage

// File: rtl/register_file_vectorial_vector_register.sv
// rtl/register_file_vectorial_vector_register.sv - one vector row with async clear and whole-vector load
module vector_register #(
  parameter int WIDTH       = 32,
  parameter int VECTOR_SIZE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d [VECTOR_SIZE],
  output logic [WIDTH-1:0] q [VECTOR_SIZE]
);

  // Row storage: cleared asynchronously, replaced as a whole when load is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        q[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        q[i] <= d[i];
      end
    end
  end

endmodule

// File: rtl/register_file_vectorial.sv
// rtl/register_file_vectorial.sv - 2-read/1-write vector register file; REGISTER_FILE_VECTORIAL_BYPASS_EN enables write-first forwarding
module register_file_vectorial
  import register_file_vectorial_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int VECTOR_SIZE  = DEFAULT_VECTOR_SIZE,
  parameter int NUM_VECTORES = DEFAULT_NUM_VECTORES,
  parameter int AW           = (NUM_VECTORES > 1) ? $clog2(NUM_VECTORES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we3,
  input  logic [AW-1:0]    v1,
  input  logic [AW-1:0]    v2,
  input  logic [AW-1:0]    v3,
  input  logic [WIDTH-1:0] wd3 [VECTOR_SIZE],
  output logic [WIDTH-1:0] vd1 [VECTOR_SIZE],
  output logic [WIDTH-1:0] vd2 [VECTOR_SIZE]
);

  logic [WIDTH-1:0]        rows [NUM_VECTORES][VECTOR_SIZE];
  logic [NUM_VECTORES-1:0] load;

  // Row select: an out-of-range v3 matches no row, so the write is dropped
  always_comb begin
    load = '0;
    for (int r = 0; r < NUM_VECTORES; r++) begin
      load[r] = we3 && (v3 == AW'(r));
    end
  end

  for (genvar g = 0; g < NUM_VECTORES; g++) begin : g_row
    vector_register #(
      .WIDTH       (WIDTH),
      .VECTOR_SIZE (VECTOR_SIZE)
    ) u_row (
      .clk  (clk),
      .rst  (rst),
      .load (load[g]),
      .d    (wd3),
      .q    (rows[g])
    );
  end

  logic fwd1;
  logic fwd2;

`ifdef REGISTER_FILE_VECTORIAL_BYPASS_EN
  // Forward only for an accepted write (in-range index, not in reset)
  always_comb begin
    fwd1 = (|load) && !rst && (v1 == v3);
    fwd2 = (|load) && !rst && (v2 == v3);
  end
`else
  // No forwarding: reads see stored contents until the writing edge
  always_comb begin
    fwd1 = 1'b0;
    fwd2 = 1'b0;
  end
`endif

  // Read muxes: out-of-range indices fall through to zero
  always_comb begin
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      vd1[i] = '0;
      vd2[i] = '0;
    end
    for (int r = 0; r < NUM_VECTORES; r++) begin
      if (v1 == AW'(r)) vd1 = rows[r];
      if (v2 == AW'(r)) vd2 = rows[r];
    end
    if (fwd1) vd1 = wd3;
    if (fwd2) vd2 = wd3;
  end

endmodule

// File: tb/tb_register_file_vectorial.sv
// tb/tb_register_file_vectorial.sv - randomized self-checking bench for register_file_vectorial
module tb_register_file_vectorial;

  typedef logic [31:0] vec_t [16];

  logic       clk;
  logic       rst;
  logic       we3;
  logic [2:0] v1;
  logic [2:0] v2;
  logic [2:0] v3;
  vec_t       wd3;
  vec_t       vd1;
  vec_t       vd2;

  vec_t mem [8];
  int   n_cmp;
  int   n_bad;

`ifdef REGISTER_FILE_VECTORIAL_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  register_file_vectorial dut (
    .clk (clk),
    .rst (rst),
    .we3 (we3),
    .v1  (v1),
    .v2  (v2),
    .v3  (v3),
    .wd3 (wd3),
    .vd1 (vd1),
    .vd2 (vd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] flat(input vec_t v);
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[i*32 +: 32] = v[i];
    return f;
  endfunction

  // What a read port must show right now, from the storage model and the port rules
  function automatic vec_t exp_read(input logic [2:0] idx);
    vec_t z;
    for (int i = 0; i < 16; i++) z[i] = '0;
    if (rst) return z;
    if (BYPASS && we3 && idx == v3) return wd3;
    return mem[idx];
  endfunction

  task automatic fill(input logic [31:0] val);
    for (int i = 0; i < 16; i++) wd3[i] = val;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) wd3[i] = $urandom;
  endtask

  task automatic clear_model();
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < 16; i++) mem[r][i] = '0;
  endtask

  // One rising edge; the model takes the write the DUT sees at that edge
  task automatic tick();
    @(posedge clk);
    if (we3 && !rst) mem[v3] = wd3;
    #1;
  endtask

  task automatic write_vec(input logic [2:0] idx);
    @(negedge clk);
    we3 = 1'b1;
    v3  = idx;
    tick();
    @(negedge clk);
    we3 = 1'b0;
  endtask

  task automatic test_reset();
    vec_t e;
    rst = 1'b1; we3 = 1'b1; v3 = 3'd2; v1 = 3'd2; v2 = 3'd0;
    fill(32'hFFFFFFFF);
    clear_model();
    tick();
    tick();
    e = exp_read(v1);
    n_cmp++;
    if (flat(vd1) !== flat(e)) begin
      n_bad++; $display("FAIL reset_vd1 got=%h want=%h", flat(vd1), flat(e));
    end
    e = exp_read(v2);
    n_cmp++;
    if (flat(vd2) !== flat(e)) begin
      n_bad++; $display("FAIL reset_vd2 got=%h want=%h", flat(vd2), flat(e));
    end
    @(negedge clk);
    rst = 1'b0; we3 = 1'b0;
    #1;
    e = exp_read(v1);
    n_cmp++;
    if (flat(vd1) !== flat(e)) begin
      n_bad++; $display("FAIL reset_write_discarded got=%h want=%h", flat(vd1), flat(e));
    end
  endtask

  task automatic test_directed();
    vec_t e;
    fill(32'hABCDEFFF);
    write_vec(3'd2);
    v1 = 3'd2; v2 = 3'd1; #1;
    e = exp_read(v1); n_cmp++;
    if (flat(vd1) !== flat(e)) begin
      n_bad++; $display("FAIL dir_v2_vd1 got=%h want=%h", flat(vd1), flat(e));
    end
    e = exp_read(v2); n_cmp++;
    if (flat(vd2) !== flat(e)) begin
      n_bad++; $display("FAIL dir_v1_zero got=%h want=%h", flat(vd2), flat(e));
    end
    fill(32'h11111111);
    write_vec(3'd4);
    v1 = 3'd1; v2 = 3'd4; #1;
    e = exp_read(v1); n_cmp++;
    if (flat(vd1) !== flat(e)) begin
      n_bad++; $display("FAIL dir_r1_zero got=%h want=%h", flat(vd1), flat(e));
    end
    e = exp_read(v2); n_cmp++;
    if (flat(vd2) !== flat(e)) begin
      n_bad++; $display("FAIL dir_r4 got=%h want=%h", flat(vd2), flat(e));
    end
    v1 = 3'd2; #1;
    e = exp_read(v1); n_cmp++;
    if (flat(vd1) !== flat(e) || vd1[7] !== 32'hABCDEFFF) begin
      n_bad++; $display("FAIL dir_r2_kept got=%h want=%h", flat(vd1), flat(e));
    end
    v1 = 3'd7; v2 = 3'd6; #1;
    e = exp_read(v1); n_cmp++;
    if (flat(vd1) !== flat(e)) begin
      n_bad++; $display("FAIL never_written_7 got=%h want=%h", flat(vd1), flat(e));
    end
    e = exp_read(v2); n_cmp++;
    if (flat(vd2) !== flat(e)) begin
      n_bad++; $display("FAIL never_written_6 got=%h want=%h", flat(vd2), flat(e));
    end
    for (int i = 0; i < 16; i++) wd3[i] = i * 32'h01010101;
    write_vec(3'd5);
    v1 = 3'd5; v2 = 3'd5; #1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (vd1[i] !== i * 32'h01010101) begin
        n_bad++; $display("FAIL per_element[%0d] got=%h want=%h", i, vd1[i], i * 32'h01010101);
      end
    end
    n_cmp++;
    if (flat(vd2) !== flat(vd1) || flat(vd2) !== flat(mem[5])) begin
      n_bad++; $display("FAIL same_index_ports got=%h want=%h", flat(vd2), flat(mem[5]));
    end
  endtask

  task automatic test_same_cycle();
    vec_t e;
    vec_t old3;
    old3 = mem[3];
    @(negedge clk);
    we3 = 1'b1; v3 = 3'd3; v1 = 3'd3; v2 = 3'd4;
    fill(32'h5A5A5A5A);
    #1;
    e = BYPASS ? wd3 : old3; n_cmp++;
    if (flat(vd1) !== flat(e) || flat(vd1) !== flat(exp_read(v1))) begin
      n_bad++; $display("FAIL same_cycle_pre got=%h want=%h", flat(vd1), flat(e));
    end
    e = exp_read(v2); n_cmp++;
    if (flat(vd2) !== flat(e)) begin
      n_bad++; $display("FAIL same_cycle_other_port got=%h want=%h", flat(vd2), flat(e));
    end
    tick();
    n_cmp++;
    if (vd1[0] !== 32'h5A5A5A5A || flat(vd1) !== flat(mem[3])) begin
      n_bad++; $display("FAIL same_cycle_post got=%h want=%h", flat(vd1), flat(mem[3]));
    end
    @(negedge clk);
    we3 = 1'b0;
  endtask

  task automatic test_reset_mid();
    vec_t e;
    @(negedge clk);
    #2;
    rst = 1'b1;
    clear_model();
    we3 = 1'b1; v3 = 3'd2; v1 = 3'd2; v2 = 3'd4;
    fill_random();
    #1;
    e = exp_read(v1); n_cmp++;
    if (flat(vd1) !== flat(e)) begin
      n_bad++; $display("FAIL mid_reset_vd1 got=%h want=%h", flat(vd1), flat(e));
    end
    e = exp_read(v2); n_cmp++;
    if (flat(vd2) !== flat(e)) begin
      n_bad++; $display("FAIL mid_reset_vd2 got=%h want=%h", flat(vd2), flat(e));
    end
    tick();
    @(negedge clk);
    rst = 1'b0; we3 = 1'b0;
    #1;
    for (int r = 0; r < 8; r++) begin
      v1 = 3'(r); #1;
      e = exp_read(v1); n_cmp++;
      if (flat(vd1) !== flat(e)) begin
        n_bad++; $display("FAIL post_reset_row%0d got=%h want=%h", r, flat(vd1), flat(e));
      end
    end
    fill_random();
    write_vec(3'd6);
    v2 = 3'd6; #1;
    e = exp_read(v2); n_cmp++;
    if (flat(vd2) !== flat(e)) begin
      n_bad++; $display("FAIL resume_write got=%h want=%h", flat(vd2), flat(e));
    end
  endtask

  task automatic test_random();
    vec_t e;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      we3 = 1'($urandom_range(0, 1));
      v1  = 3'($urandom_range(0, 7));
      v2  = ($urandom_range(0, 3) == 0) ? v1 : 3'($urandom_range(0, 7));
      v3  = ($urandom_range(0, 2) == 0) ? v1 : 3'($urandom_range(0, 7));
      fill_random();
      #1;
      e = exp_read(v1); n_cmp++;
      if (flat(vd1) !== flat(e)) begin
        n_bad++; $display("FAIL rand_pre_vd1 it=%0d got=%h want=%h", n, flat(vd1), flat(e));
      end
      e = exp_read(v2); n_cmp++;
      if (flat(vd2) !== flat(e)) begin
        n_bad++; $display("FAIL rand_pre_vd2 it=%0d got=%h want=%h", n, flat(vd2), flat(e));
      end
      tick();
      e = exp_read(v1); n_cmp++;
      if (flat(vd1) !== flat(e)) begin
        n_bad++; $display("FAIL rand_post_vd1 it=%0d got=%h want=%h", n, flat(vd1), flat(e));
      end
    end
    @(negedge clk);
    we3 = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_directed();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/register_file_vectorial.md
REGISTER_FILE_VECTORIAL -- requirements
Module: register_file_vectorial

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the bit width of one vector element.
REQ-002 Parameter VECTOR_SIZE, default 16, SHALL set the number of elements per vector register.
REQ-003 Parameter NUM_VECTORES, default 8, SHALL set the number of vector registers; address width AW = $clog2(NUM_VECTORES).
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 we3  input  1  SHALL be the write enable for write port 3.
REQ-007 v1  input  AW  SHALL be the read-port-1 register index.
REQ-008 v2  input  AW  SHALL be the read-port-2 register index.
REQ-009 v3  input  AW  SHALL be the write-port-3 register index.
REQ-010 wd3  input  VECTOR_SIZE x WIDTH (unpacked, element [i])  SHALL be the write data vector.
REQ-011 vd1  output  VECTOR_SIZE x WIDTH  SHALL be the read data of register v1.
REQ-012 vd2  output  VECTOR_SIZE x WIDTH  SHALL be the read data of register v2.

Function
REQ-013 Storage SHALL be NUM_VECTORES registers, each VECTOR_SIZE elements of WIDTH bits.
REQ-014 On rising clk with we3=1 and rst=0, all VECTOR_SIZE elements of register v3 SHALL be replaced by wd3, element i from wd3[i].
REQ-015 With we3=0, no register SHALL change.
REQ-016 Writes SHALL be whole-vector only; no per-element mask.
REQ-017 vd1/vd2 SHALL be combinational (zero-cycle latency) functions of v1/v2 and stored contents.
REQ-018 A write SHALL become visible on vd1/vd2 immediately after the writing clock edge.
REQ-019 Both read ports SHALL be independent; v1==v2 SHALL return identical data on both.
REQ-020 A never-written register SHALL read all-zero.
REQ-021 If NUM_VECTORES is not a power of two, an out-of-range index SHALL read zero, and a write to it SHALL be ignored.
REQ-022 Simultaneous read and write of the same index without bypass: read SHALL return the old contents until the edge.

Reset
REQ-023 rst=1 SHALL asynchronously clear every element of every register to 0, so vd1/vd2 read 0 regardless of index.
REQ-024 rst asserted SHALL override we3; a write coincident with reset SHALL be discarded.
REQ-025 Reset deassertion mid-operation SHALL resume normal writes at the next rising clk.

Configuration
REQ-026 Macro REGISTER_FILE_VECTORIAL_BYPASS_EN defined: when we3=1 and v1==v3 (resp. v2==v3), vd1 (resp. vd2) SHALL return wd3 combinationally (write-first forwarding), except while rst=1 (reads 0).
REQ-027 Macro undefined: no forwarding; REQ-022 applies.

Structure
REQ-028 A shared package SHALL hold default WIDTH/VECTOR_SIZE/NUM_VECTORES constants and the element/vector typedefs (element_t = logic [WIDTH-1:0], vector_t = element_t [VECTOR_SIZE]).
REQ-029 One sub-module, vector_register (one vector row: async clear, enabled load, WIDTH x VECTOR_SIZE storage), SHALL be instantiated NUM_VECTORES times via generate; read muxing and bypass live in the top.

Verification
REQ-030 Reset, then we3=1, v3=2, wd3[all]=32'hABCDEFFF, one edge; we3=0, v1=2, v2=1 -> vd1 all 32'hABCDEFFF, vd2 all 0.
REQ-031 we3=1, v3=4, wd3[all]=32'h11111111, one edge; v1=1, v2=4 -> vd1 all 0, vd2 all 32'h11111111; then v1=2, v2=4 -> vd1 all 32'hABCDEFFF, vd2 all 32'h11111111.
REQ-032 v1=7, v2=6 (never written) -> vd1 and vd2 all 0.
REQ-033 Distinct per-element data wd3[i]=i*32'h01010101 to v3=5 -> vd1[i] matches per element with v1=5.
REQ-034 Assert rst between clock edges after REQ-031 -> vd1/vd2 go to 0 immediately; we3=1 during reset leaves all registers 0.
REQ-035 we3=1, v3=3, v1=3, wd3=32'h5A5A5A5A before the edge -> with BYPASS_EN vd1 = 32'h5A5A5A5A immediately; without it vd1 = 0 until the edge, then 32'h5A5A5A5A.
